tros_multi_readout: RTL and testbench
=====================================

// Module: tros_multi_readout
// PURPOSE
//  Next-generation serial readout for the temperature ring-oscillator array.
//  Snapshots the latched cycle counts of NUM_CH frequency-measurement channels.
//  Streams them as framed, Manchester-coded bits to the RP2040:
//   - single mode: one selected channel;
//   - scan mode: every channel in order.
//  Sits between the per-oscillator counter blocks and the top-level output pin.
// PARAMETERS
//  NUM_CH    4    number of counter channels (1..16)
//  CNT_W     20   width of each cycle count
//  GAP_BITS  2    idle zero bits between frames in scan mode (0 allowed)
//  ID_W      -    localparam: max(1, clog2(NUM_CH)); width of channel-ID field
// PORTS
//  clk          in   1              system clock (RP2040-driven), sole clock
//  reset        in   1              synchronous, active-high reset
//  ena          in   1              design enable, async; 3-FF synchronised inside
//  send_req     in   1              transmit request, async; 3-FF synchronised, rising-edge triggered
//  scan_mode    in   1              1 = send all channels, 0 = send ch_sel only; sampled at trigger
//  ch_sel       in   ID_W           channel for single mode; sampled at trigger
//  cnt_bus      in   NUM_CH*CNT_W   latched counts; channel i at [i*CNT_W +: CNT_W]
//  serial_bit   out  1              current frame bit, MSB first
//  data_stream  out  1              serial_bit ^ clk (Manchester line code)
//  busy         out  1              high while any frame or gap bit is being sent
//  done         out  1              one-cycle pulse after the last bit of the request
// BEHAVIOUR
//  - Frame, MSB first: HEADER 4'b1010 | channel ID (ID_W) | count (CNT_W) [| CRC8].
//  - FRAME_W = 4 + ID_W + CNT_W (+8 with CRC).
//  - Trigger: edge = sync_req[2] & ~sync_req_d, with ena_sync[2]=1 and FSM in IDLE.
//  - Edge detected in cycle T:
//     - at T+1, snapshot register captures the whole cnt_bus;
//     - serial_bit = frame MSB (1); busy=1.
//  - One bit per cycle; frame bits occupy T+1..T+FRAME_W.
//  - FSM states:
//     - IDLE: serial_bit=0, busy=0.
//     - SHIFT: bit counter runs FRAME_W-1..0.
//     - GAP: GAP_BITS zero cycles, busy stays 1.
//  - Transitions:
//     - IDLE->SHIFT on trigger.
//     - SHIFT->GAP at end of frame if scan_mode, more channels remain and GAP_BITS>0.
//     - SHIFT->SHIFT (next channel loaded) if GAP_BITS=0 and more channels remain.
//     - GAP->SHIFT after GAP_BITS cycles.
//     - SHIFT->IDLE after the last frame.
//  - done pulses in the first IDLE cycle; no gap follows the last frame.
//  - Scan order is channel 0..NUM_CH-1; all frames use the single T+1 snapshot.
//  - ch_sel >= NUM_CH in single mode: ID field = ch_sel, count field = all zeros.
//  - send_req edges while busy are ignored and not queued.
//  - A held-high send_req never retriggers.
//  - ena_sync[2]=0 in any state:
//     - next cycle IDLE, shift and snapshot regs cleared;
//     - serial_bit=0, busy=0, no done.
//  - Reset behaves the same as ena low.
//  - Reset values:
//     - serial_bit=0, busy=0, done=0;
//     - syncs, edge detector, snapshot, counters all 0;
//     - data_stream therefore equals clk.
// CONFIGURATION
//  TROS_READOUT_CRC8_EN defined:
//   - 8-bit CRC appended to every frame;
//   - polynomial x^8+x^2+x+1 (0x07), init 0x00, no final XOR;
//   - computed MSB-first over the ID and count fields only;
//   - FRAME_W grows by 8.
//  Not defined: frame ends after the count; no CRC logic is built.
// STRUCTURE
//  - Shared package tros_pkg holds:
//     - TROS_HEADER = 4'b1010 and the CRC8 polynomial constant;
//     - FSM state encoding (IDLE/SHIFT/GAP);
//     - clog2 helper function.
//  - One sub-module, tros_crc8: serial CRC with clear, enable and bit inputs.
//     - Instantiated only under TROS_READOUT_CRC8_EN.
//  - Synchronisers and FSM stay in this module.
// TESTING (NUM_CH=4, CNT_W=20, ID_W=2, GAP_BITS=2, no CRC unless stated)
//  1. Single mode:
//     - stimulus: ch_sel=2, ch2=20'hABCDE, send_req rise;
//     - response: 26 bits 1010_10_1010_1011_1100_1101_1110 at T+1..T+26, done at T+27.
//  2. Scan mode, counts 1,2,3,4:
//     - response: 4 frames, IDs 0..3, 2 zero bits between frames;
//     - busy high exactly 110 cycles, one done pulse.
//  3. Snapshot coherence:
//     - stimulus: change cnt_bus during frame 1 of a scan;
//     - response: frames 1..3 report the trigger-time values.
//  4. Retrigger: send_req toggled twice while busy, then held high -> exactly one transmission.
//  5. Abort:
//     - stimulus: reset (then, separately, ena low) at bit 10;
//     - response: next cycle serial_bit=0, busy=0, no done;
//     - a fresh send_req rise then sends a full frame.
//  6. CRC8_EN:
//     - ID=0, count=0 -> CRC 8'h00, 34-bit frame;
//     - random counts match the bench CRC reference model;
//     - ch_sel=3 with NUM_CH=3 -> zero count, CRC over ID 2'b11.

Source files
------------

// File: rtl/tros_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tros_pkg                                                     |
// | Description : Shared constants, FSM state encoding and a width helper for  |
// |               the temperature ring-oscillator multi-channel readout.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package tros_pkg;

  // Fixed frame header, sent MSB first ahead of every frame.
  localparam logic [3:0] TROS_HEADER    = 4'b1010;
  // CRC8 polynomial x^8+x^2+x+1, with the x^8 term implied.
  localparam logic [7:0] TROS_CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tros_state_e;

  // Ceiling log2, never returning less than one bit so that single-entry
  // fields still have a legal width.
  function automatic int tros_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tros_crc8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tros_crc8                                                    |
// | Description : Bit-serial CRC8 (poly 0x07, init 0x00, no final XOR),        |
// |               MSB-first. Clear has priority over enable.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tros_crc8
  import tros_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       feedback;

  // Next CRC value: clear, otherwise shift one message bit in when enabled.
  always_comb begin
    feedback = crc_q[7] ^ din;
    crc_d    = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (feedback ? TROS_CRC8_POLY : 8'h00);
    end
  end

  // CRC state register.
  always_ff @(posedge clk) begin
    if (reset) crc_q <= 8'h00;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/tros_multi_readout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tros_multi_readout                                           |
// | Description : Snapshots NUM_CH latched oscillator counts and streams them  |
// |               as framed, Manchester-coded bits (single channel or scan).   |
// |               Frame: HEADER | channel ID | count [| CRC8].                 |
// |               Optional CRC8 trailer: define TROS_READOUT_CRC8_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tros_multi_readout
  import tros_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = 20,
  parameter  int GAP_BITS = 2,
  localparam int ID_W     = tros_clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ena,
  input  logic                    send_req,
  input  logic                    scan_mode,
  input  logic [ID_W-1:0]         ch_sel,
  input  logic [NUM_CH*CNT_W-1:0] cnt_bus,
  output logic                    serial_bit,
  output logic                    data_stream,
  output logic                    busy,
  output logic                    done
);

  localparam int BASE_W = 4 + ID_W + CNT_W;
`ifdef TROS_READOUT_CRC8_EN
  localparam int CRC_W  = 8;
`else
  localparam int CRC_W  = 0;
`endif
  localparam int FRAME_W = BASE_W + CRC_W;
  localparam int BC_W    = tros_clog2(FRAME_W);
  localparam int GC_W    = tros_clog2(GAP_BITS + 1);

  localparam logic [BC_W-1:0] BIT_LOAD = BC_W'(FRAME_W - 1);
  localparam logic [GC_W-1:0] GAP_LOAD = GC_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [ID_W-1:0] LAST_CH  = ID_W'(NUM_CH - 1);

  tros_state_e               state_q, state_d;
  logic [2:0]                ena_sync_q, ena_sync_d;
  logic [2:0]                sync_req_q, sync_req_d;
  logic                      sync_req_dly_q, sync_req_dly_d;
  logic [NUM_CH*CNT_W-1:0]   snap_q, snap_d;
  logic [BASE_W-1:0]         shift_q, shift_d;
  logic [BC_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [GC_W-1:0]           gap_cnt_q, gap_cnt_d;
  logic [ID_W-1:0]           ch_q, ch_d;
  logic                      scan_q, scan_d;
  logic                      done_q, done_d;

  logic                      req_edge;
  logic                      load_frame;
  logic [ID_W-1:0]           load_id;
  logic [NUM_CH*CNT_W-1:0]   load_src;

  // Channel count lookup; IDs beyond the populated channels read as zero.
  function automatic logic [CNT_W-1:0] pick_count(
    input logic [NUM_CH*CNT_W-1:0] bus,
    input logic [ID_W-1:0]         id
  );
    pick_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (id == ID_W'(i)) pick_count = bus[i*CNT_W +: CNT_W];
    end
  endfunction

  // Synchronisers, edge detect and the readout FSM next-state logic.
  always_comb begin
    ena_sync_d     = {ena_sync_q[1:0], ena};
    sync_req_d     = {sync_req_q[1:0], send_req};
    sync_req_dly_d = sync_req_q[2];
    req_edge       = sync_req_q[2] & ~sync_req_dly_q;

    state_d    = state_q;
    snap_d     = snap_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ch_d       = ch_q;
    scan_d     = scan_q;
    done_d     = 1'b0;
    load_frame = 1'b0;
    load_id    = ch_q;
    load_src   = snap_q;

    if (!ena_sync_q[2]) begin
      // Disabled: abandon any transfer silently and wipe captured data.
      state_d   = ST_IDLE;
      snap_d    = '0;
      shift_d   = '0;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
      ch_d      = '0;
      scan_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_edge) begin
            // The snapshot is not visible yet, so the first frame is built
            // straight from the live bus it is copied from.
            state_d    = ST_SHIFT;
            snap_d     = cnt_bus;
            scan_d     = scan_mode;
            ch_d       = scan_mode ? '0 : ch_sel;
            load_frame = 1'b1;
            load_id    = scan_mode ? '0 : ch_sel;
            load_src   = cnt_bus;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            shift_d   = shift_q << 1;
          end else if (scan_q && (ch_q != LAST_CH)) begin
            ch_d = ch_q + 1'b1;
            if (GAP_BITS > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LOAD;
              shift_d   = '0;
            end else begin
              load_frame = 1'b1;
              load_id    = ch_q + 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            shift_d = '0;
            done_d  = 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            state_d    = ST_SHIFT;
            load_frame = 1'b1;
            load_id    = ch_q;
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (load_frame) begin
        shift_d   = {TROS_HEADER, load_id, pick_count(load_src, load_id)};
        bit_cnt_d = BIT_LOAD;
      end
    end
  end

  // State registers; reset clears everything exactly like a disable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ena_sync_q     <= '0;
      sync_req_q     <= '0;
      sync_req_dly_q <= 1'b0;
      snap_q         <= '0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      ch_q           <= '0;
      scan_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ena_sync_q     <= ena_sync_d;
      sync_req_q     <= sync_req_d;
      sync_req_dly_q <= sync_req_dly_d;
      snap_q         <= snap_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      ch_q           <= ch_d;
      scan_q         <= scan_d;
      done_q         <= done_d;
    end
  end

`ifdef TROS_READOUT_CRC8_EN
  localparam logic [BC_W-1:0] CRC_START   = BC_W'(CRC_W);
  localparam logic [BC_W-1:0] PAYLOAD_END = BC_W'(CRC_W + ID_W + CNT_W);

  logic [7:0] crc_value;
  logic       crc_en;
  logic       crc_clr;

  // CRC covers only ID and count bits; it is frozen while its own bits go out.
  assign crc_en  = (state_q == ST_SHIFT) && (bit_cnt_q >= CRC_START) &&
                   (bit_cnt_q < PAYLOAD_END);
  assign crc_clr = load_frame | (state_q != ST_SHIFT) | ~ena_sync_q[2];

  tros_crc8 u_crc8 (
    .clk   (clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (shift_q[BASE_W-1]),
    .crc   (crc_value)
  );

  // Line bit: frame body from the shifter, then the CRC trailer MSB first.
  always_comb begin
    serial_bit = 1'b0;
    if (state_q == ST_SHIFT) begin
      if (bit_cnt_q < CRC_START) serial_bit = crc_value[bit_cnt_q[2:0]];
      else                       serial_bit = shift_q[BASE_W-1];
    end
  end
`else
  // Line bit: MSB of the shifter while a frame is on the wire.
  always_comb begin
    serial_bit = 1'b0;
    if (state_q == ST_SHIFT) serial_bit = shift_q[BASE_W-1];
  end
`endif

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign data_stream = serial_bit ^ clk;

endmodule
`default_nettype wire

// File: tb/tb_tros_multi_readout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tros_multi_readout                                        |
// | Description : Self-checking bench for tros_multi_readout (NUM_CH=4 main    |
// |               instance, NUM_CH=3 instance for out-of-range channel IDs).   |
// |               Honours TROS_READOUT_CRC8_EN when defined.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tros_multi_readout;

`ifdef TROS_READOUT_CRC8_EN
  localparam int FW = 34;
`else
  localparam int FW = 26;
`endif
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset, ena, scan_mode;
  logic        send_req, send_req3;
  logic [1:0]  ch_sel, ch_sel3;
  logic [79:0] cnt_bus;
  logic [59:0] cnt_bus3;
  logic        serial_bit4, data_stream4, busy4, done4;
  logic        serial_bit3, data_stream3, busy3, done3;

  logic        mon3;
  logic        m_sb, m_busy, m_done;
  assign m_sb   = mon3 ? serial_bit3 : serial_bit4;
  assign m_busy = mon3 ? busy3       : busy4;
  assign m_done = mon3 ? done3       : done4;

  always #5 clk = ~clk;

  tros_multi_readout #(.NUM_CH(4), .CNT_W(20), .GAP_BITS(2)) dut4 (
    .clk(clk), .reset(reset), .ena(ena), .send_req(send_req),
    .scan_mode(scan_mode), .ch_sel(ch_sel), .cnt_bus(cnt_bus),
    .serial_bit(serial_bit4), .data_stream(data_stream4),
    .busy(busy4), .done(done4)
  );

  tros_multi_readout #(.NUM_CH(3), .CNT_W(20), .GAP_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .ena(ena), .send_req(send_req3),
    .scan_mode(scan_mode), .ch_sel(ch_sel3), .cnt_bus(cnt_bus3),
    .serial_bit(serial_bit3), .data_stream(data_stream3),
    .busy(busy3), .done(done3)
  );

  int total = 0;
  int bad   = 0;

  logic cap [0:511];
  int   cap_n, done_n, done_k, last_busy_k;
  bit   idle_bad;
  logic exp_bits [0:511];
  int   exp_n;

  typedef struct {
    logic        scan;
    logic [1:0]  sel;
    logic [79:0] bus;
    int          nframes;
    logic [25:0] head;
    logic [25:0] last;
  } vec_t;
  vec_t tbl [0:4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8_ref(input logic [21:0] payload);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 21; i >= 0; i--) begin
      fb = c[7] ^ payload[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic push(input logic b);
    exp_bits[exp_n] = b;
    exp_n++;
  endtask

  // Reference stream: frames per channel with zero gaps only between frames.
  task automatic model(input bit scan, input int sel, input logic [79:0] bus, input int num);
    int first_id, last_id;
    first_id = scan ? 0 : sel;
    last_id  = scan ? num - 1 : sel;
    exp_n = 0;
    for (int id = first_id; id <= last_id; id++) begin
      logic [3:0]  hdr;
      logic [1:0]  idb;
      logic [19:0] cnt;
      logic [21:0] payload;
      logic [7:0]  crc;
      hdr     = 4'b1010;
      idb     = id[1:0];
      cnt     = (id < num) ? bus[id*20 +: 20] : 20'h0;
      payload = {idb, cnt};
      crc     = crc8_ref(payload);
      for (int i = 3; i >= 0; i--)  push(hdr[i]);
      for (int i = 21; i >= 0; i--) push(payload[i]);
`ifdef TROS_READOUT_CRC8_EN
      for (int i = 7; i >= 0; i--)  push(crc[i]);
`endif
      if (id != last_id) for (int g = 0; g < GAP; g++) push(1'b0);
    end
  endtask

  // Observe the monitored DUT until 40 idle cycles follow its busy window.
  task automatic capture(output bit timeout);
    bit seen;
    cap_n = 0; done_n = 0; done_k = -1; last_busy_k = -1;
    idle_bad = 1'b0; seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (m_busy) begin
        if (cap_n < 512) cap[cap_n] = m_sb;
        cap_n++;
        last_busy_k = k;
        seen = 1'b1;
      end else if (m_sb) begin
        idle_bad = 1'b1;
      end
      if (m_done) begin
        done_n++;
        done_k = k;
      end
      if (seen && !m_busy && (k - last_busy_k) >= 40) break;
    end
    timeout = !seen;
  endtask

  task automatic check_tx(input string tag, input bit timeout);
    int mism;
    mism = 0;
    check({tag, ".timeout"},  64'(timeout),  64'd0);
    check({tag, ".busy_len"}, 64'(cap_n),    64'(exp_n));
    check({tag, ".done_cnt"}, 64'(done_n),   64'd1);
    check({tag, ".done_at"},  64'(done_k),   64'(last_busy_k + 1));
    check({tag, ".idle_low"}, 64'(idle_bad), 64'd0);
    for (int i = 0; i < exp_n && i < cap_n && i < 512; i++)
      if (cap[i] !== exp_bits[i]) mism++;
    check({tag, ".stream"},   64'(mism),     64'd0);
  endtask

  function automatic logic [25:0] get26(input int off);
    logic [25:0] r;
    r = '0;
    for (int i = 0; i < 26; i++) r = {r[24:0], cap[off + i]};
    return r;
  endfunction

  task automatic idle_req(input int n);
    send_req  = 1'b0;
    send_req3 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit to, ok;
    int n_busy, n_done, k_drop;
    logic [79:0] orig;

    tbl[0] = '{scan: 1'b0, sel: 2'd2, bus: {20'h11111, 20'hABCDE, 20'h22222, 20'h33333},
               nframes: 1, head: {4'hA, 2'd2, 20'hABCDE}, last: {4'hA, 2'd2, 20'hABCDE}};
    tbl[1] = '{scan: 1'b1, sel: 2'd0, bus: {20'd4, 20'd3, 20'd2, 20'd1},
               nframes: 4, head: {4'hA, 2'd0, 20'd1}, last: {4'hA, 2'd3, 20'd4}};
    tbl[2] = '{scan: 1'b0, sel: 2'd0, bus: {20'h0, 20'h0, 20'h0, 20'hFFFFF},
               nframes: 1, head: {4'hA, 2'd0, 20'hFFFFF}, last: {4'hA, 2'd0, 20'hFFFFF}};
    tbl[3] = '{scan: 1'b0, sel: 2'd3, bus: {20'h00001, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF},
               nframes: 1, head: {4'hA, 2'd3, 20'h00001}, last: {4'hA, 2'd3, 20'h00001}};
    tbl[4] = '{scan: 1'b1, sel: 2'd1, bus: 80'h0,
               nframes: 4, head: {4'hA, 2'd0, 20'h0}, last: {4'hA, 2'd3, 20'h0}};

    reset = 1'b1; ena = 1'b0; scan_mode = 1'b0;
    send_req = 1'b0; send_req3 = 1'b0;
    ch_sel = '0; ch_sel3 = '0; cnt_bus = '0; cnt_bus3 = '0; mon3 = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.serial_bit", 64'(serial_bit4), 64'd0);
    check("rst.busy",       64'(busy4),       64'd0);
    check("rst.done",       64'(done4),       64'd0);
    check("rst.ds_low",     64'(data_stream4), 64'd0);
    @(posedge clk); #1;
    check("rst.ds_high",    64'(data_stream4), 64'd1);
    @(negedge clk);
    reset = 1'b0; ena = 1'b1;
    repeat (6) @(negedge clk);

    // Table-driven transactions on the 4-channel instance.
    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      scan_mode = tbl[v].scan;
      ch_sel    = tbl[v].sel;
      cnt_bus   = tbl[v].bus;
      model(tbl[v].scan, int'(tbl[v].sel), tbl[v].bus, 4);
      send_req = 1'b1;
      capture(to);
      idle_req(4);
      check_tx(tag, to);
      check({tag, ".busy_hand"}, 64'(cap_n),
            64'(tbl[v].nframes * FW + (tbl[v].nframes - 1) * GAP));
      check({tag, ".head"}, 64'(get26(0)), 64'(tbl[v].head));
      check({tag, ".last"}, 64'(get26((tbl[v].nframes - 1) * (FW + GAP))), 64'(tbl[v].last));
    end

    // Snapshot coherence: bus changes during the first frame of a scan.
    scan_mode = 1'b1;
    orig      = {20'hDDDD4, 20'hCCCC3, 20'hBBBB2, 20'hAAAA1};
    cnt_bus   = orig;
    model(1'b1, 0, orig, 4);
    send_req  = 1'b1;
    fork
      capture(to);
      begin
        wait_busy(ok);
        repeat (5) @(negedge clk);
        cnt_bus = ~orig;
      end
    join
    idle_req(4);
    check_tx("snap", to);

    // Retrigger: two toggles while busy, then held high.
    scan_mode = 1'b0; ch_sel = 2'd1; cnt_bus = {20'h0, 20'h0, 20'h5A5A5, 20'h0};
    model(1'b0, 1, cnt_bus, 4);
    send_req = 1'b1;
    fork
      capture(to);
      begin
        wait_busy(ok);
        repeat (3) @(negedge clk); send_req = 1'b0;
        repeat (3) @(negedge clk); send_req = 1'b1;
        repeat (3) @(negedge clk); send_req = 1'b0;
        repeat (3) @(negedge clk); send_req = 1'b1;
      end
    join
    check_tx("retrig", to);
    idle_req(4);

    // Abort by reset at bit 10.
    ch_sel = 2'd2; cnt_bus = {20'h0, 20'hABCDE, 20'h0, 20'h0};
    send_req = 1'b1;
    wait_busy(ok);
    check("rabort.started", 64'(ok), 64'd1);
    send_req = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rabort.busy", 64'(busy4),       64'd0);
    check("rabort.sb",   64'(serial_bit4), 64'd0);
    n_busy = 0; n_done = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy4) n_busy++;
      if (done4) n_done++;
    end
    check("rabort.no_done", 64'(n_done), 64'd0);
    check("rabort.stay_idle", 64'(n_busy), 64'd0);
    model(1'b0, 2, cnt_bus, 4);
    send_req = 1'b1;
    capture(to);
    idle_req(4);
    check_tx("rabort.resend", to);

    // Abort by ena low at bit 10 (three-stage sync, then one cycle).
    send_req = 1'b1;
    wait_busy(ok);
    send_req = 1'b0;
    repeat (10) @(negedge clk);
    ena = 1'b0;
    k_drop = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!busy4) begin
        k_drop = i;
        break;
      end
    end
    check("eabort.drop_cycle", 64'(k_drop), 64'd4);
    check("eabort.sb", 64'(serial_bit4), 64'd0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4) n_done++;
    end
    check("eabort.no_done", 64'(n_done), 64'd0);
    ena = 1'b1;
    repeat (6) @(negedge clk);
    send_req = 1'b1;
    capture(to);
    idle_req(4);
    check_tx("eabort.resend", to);

    // Out-of-range channel on a 3-channel instance: zero count, ID kept.
    mon3 = 1'b1;
    scan_mode = 1'b0; ch_sel3 = 2'd3;
    cnt_bus3 = {20'h12345, 20'h6789A, 20'hBCDEF};
    model(1'b0, 3, {20'h0, cnt_bus3}, 3);
    send_req3 = 1'b1;
    capture(to);
    idle_req(4);
    check_tx("oor", to);
    check("oor.head", 64'(get26(0)), 64'({4'hA, 2'd3, 20'h0}));

    // Scan on the 3-channel instance ends after channel 2.
    scan_mode = 1'b1;
    model(1'b1, 0, {20'h0, cnt_bus3}, 3);
    send_req3 = 1'b1;
    capture(to);
    idle_req(4);
    check_tx("scan3", to);
    check("scan3.busy_hand", 64'(cap_n), 64'(3 * FW + 2 * GAP));
    check("scan3.last", 64'(get26(2 * (FW + GAP))), 64'({4'hA, 2'd2, 20'h12345}));
    mon3 = 1'b0;

`ifdef TROS_READOUT_CRC8_EN
    // Zero payload gives a zero CRC.
    scan_mode = 1'b0; ch_sel = 2'd0; cnt_bus = '0;
    model(1'b0, 0, cnt_bus, 4);
    send_req = 1'b1;
    capture(to);
    idle_req(4);
    check_tx("crc0", to);
    check("crc0.len", 64'(cap_n), 64'd34);
    begin
      logic [7:0] c;
      c = '0;
      for (int i = 26; i < 34; i++) c = {c[6:0], cap[i]};
      check("crc0.value", 64'(c), 64'h00);
    end

    // Random counts against the reference CRC.
    for (int r = 0; r < 3; r++) begin
      cnt_bus = {16'($urandom), 32'($urandom), 32'($urandom)};
      ch_sel  = 2'($urandom_range(0, 3));
      model(1'b0, int'(ch_sel), cnt_bus, 4);
      send_req = 1'b1;
      capture(to);
      idle_req(4);
      check_tx($sformatf("crcrnd%0d", r), to);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
